storage_bank4: RTL and testbench

Four-entry data storage bank sitting directly downstream of the 2-to-4 address decoder: it consumes the decoder's one-hot write select, stores write data into the selected entry, and tracks a valid bit per entry. It provides a registered random-access read port and a sequential dump engine that streams all valid entries out over a valid/ready handshake. It also flags illegal (non-one-hot) write selects.

---
 rtl/storage_bank4.sv | 184 ++++++++++++++++++
 tb/tb_storage_bank4.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/storage_bank4.sv
// storage_bank4: four-entry storage bank with one-hot write select,
// registered read port and a valid/ready dump engine.
module storage_bank4 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [3:0]        wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    input  logic [1:0]        rsel,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [3:0]        valid_mask,
    output logic [2:0]        count,
    output logic              sel_err,
    input  logic              dump_start,
    output logic [DATA_W-1:0] dump_data,
    output logic [1:0]        dump_idx,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_busy,
    output logic              dump_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [4];
    logic [DATA_W-1:0] mem_d [4];
    logic [3:0]        valid_q, valid_d;
    logic [2:0]        count_q, count_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [3:0]        pend_q, pend_d;
    logic [DATA_W-1:0] ddata_q, ddata_d;
    logic [1:0]        didx_q, didx_d;
    logic              dvalid_q, dvalid_d;
    logic              done_q, done_d;

    logic              wr_ok;
    logic              wr_bad;
    logic [1:0]        low_idx;

    // Classify the write strobe: legal one-hot writes vs. illegal selects.
    always_comb begin
        wr_ok  = we && !clr && $onehot(wsel);
        wr_bad = we && !clr && !$onehot(wsel);
    end

    // Storage array, valid bits, popcount, sticky error and read port.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_d[i] = mem_q[i];
        end
        valid_d = valid_q;
        err_d   = err_q;
        if (clr) begin
            valid_d = '0;
            err_d   = 1'b0;
        end else if (wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wsel[i]) begin
                    mem_d[i]   = wdata;
                    valid_d[i] = 1'b1;
                end
            end
        end else if (wr_bad) begin
            err_d = 1'b1;
        end
        count_d = {2'b0, valid_d[0]} + {2'b0, valid_d[1]}
                + {2'b0, valid_d[2]} + {2'b0, valid_d[3]};
        rdata_d  = mem_q[rsel];
        rvalid_d = valid_q[rsel];
    end

    // Lowest pending entry of the dump snapshot.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = 2'(i);
            end
        end
    end

    // Dump FSM; a SCAN cycle that pulsed done returns to IDLE next edge.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ddata_d  = ddata_q;
        didx_d   = didx_q;
        dvalid_d = dvalid_q;
        done_d   = 1'b0;
        if (clr) begin
            state_d  = IDLE;
            dvalid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dump_start) begin
                        pend_d  = valid_q;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (done_q) begin
                        state_d = IDLE;
                    end else if (pend_q == 4'b0) begin
                        done_d = 1'b1;
                    end else begin
                        ddata_d         = mem_q[low_idx];
                        didx_d          = low_idx;
                        pend_d[low_idx] = 1'b0;
                        dvalid_d        = 1'b1;
                        state_d         = SEND;
                    end
                end
                SEND: begin
                    if (dump_ready) begin
                        dvalid_d = 1'b0;
                        state_d  = SCAN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            valid_q  <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
            pend_q   <= '0;
            ddata_q  <= '0;
            didx_q   <= '0;
            dvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
            valid_q  <= valid_d;
            count_q  <= count_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            ddata_q  <= ddata_d;
            didx_q   <= didx_d;
            dvalid_q <= dvalid_d;
            done_q   <= done_d;
        end
    end

    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign valid_mask = valid_q;
    assign count      = count_q;
    assign sel_err    = err_q;
    assign dump_data  = ddata_q;
    assign dump_idx   = didx_q;
    assign dump_valid = dvalid_q;
    assign dump_busy  = (state_q != IDLE);
    assign dump_done  = done_q;

endmodule

// File: tb/tb_storage_bank4.sv
// tb_storage_bank4: directed self-checking bench for storage_bank4.
// Expected values are hand-computed constants per step.
module tb_storage_bank4;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [3:0] wsel;
    logic [7:0] wdata;
    logic       clr;
    logic [1:0] rsel;
    logic [7:0] rdata;
    logic       rvalid;
    logic [3:0] valid_mask;
    logic [2:0] count;
    logic       sel_err;
    logic       dump_start;
    logic [7:0] dump_data;
    logic [1:0] dump_idx;
    logic       dump_valid;
    logic       dump_ready;
    logic       dump_busy;
    logic       dump_done;

    int n_checks = 0;
    int n_fail   = 0;

    storage_bank4 #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .wsel       (wsel),
        .wdata      (wdata),
        .clr        (clr),
        .rsel       (rsel),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .valid_mask (valid_mask),
        .count      (count),
        .sel_err    (sel_err),
        .dump_start (dump_start),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic v,
                            input logic [1:0] idx, input logic [7:0] d);
        chk({tag, "_valid"}, 32'(dump_valid), 32'(v));
        chk({tag, "_idx"}, 32'(dump_idx), 32'(idx));
        chk({tag, "_data"}, 32'(dump_data), 32'(d));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdata"}, 32'(rdata), 32'h0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
        chk({tag, "_mask"}, 32'(valid_mask), 32'h0);
        chk({tag, "_count"}, 32'(count), 32'h0);
        chk({tag, "_err"}, 32'(sel_err), 32'h0);
        chk({tag, "_dvalid"}, 32'(dump_valid), 32'h0);
        chk({tag, "_ddata"}, 32'(dump_data), 32'h0);
        chk({tag, "_didx"}, 32'(dump_idx), 32'h0);
        chk({tag, "_busy"}, 32'(dump_busy), 32'h0);
        chk({tag, "_done"}, 32'(dump_done), 32'h0);
    endtask

    task automatic wr(input logic [3:0] s, input logic [7:0] d);
        we    = 1'b1;
        wsel  = s;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        we         = 1'b0;
        wsel       = 4'b0;
        wdata      = 8'h0;
        clr        = 1'b0;
        rsel       = 2'd0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        #12;
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fill all four entries
        wr(4'b0001, 8'hA5);
        chk("w0_mask", 32'(valid_mask), 32'h1);
        chk("w0_count", 32'(count), 32'd1);
        wr(4'b0010, 8'h3C);
        wr(4'b0100, 8'hF0);
        wr(4'b1000, 8'h11);
        chk("full_mask", 32'(valid_mask), 32'hF);
        chk("full_count", 32'(count), 32'd4);
        rsel = 2'd2;
        tick();
        chk("rd2_data", 32'(rdata), 32'hF0);
        chk("rd2_valid", 32'(rvalid), 32'h1);

        // Read during write returns old data; overwrite keeps count
        rsel = 2'd0;
        wr(4'b0001, 8'h77);
        chk("rdw_old", 32'(rdata), 32'hA5);
        chk("ovw_count", 32'(count), 32'd4);
        tick();
        chk("rdw_new", 32'(rdata), 32'h77);

        // Illegal selects
        rsel = 2'd1;
        wr(4'b0110, 8'h99);
        chk("bad1_err", 32'(sel_err), 32'h1);
        chk("bad1_mask", 32'(valid_mask), 32'hF);
        wr(4'b0000, 8'h98);
        chk("bad0_err", 32'(sel_err), 32'h1);
        tick();
        chk("bad_rd1", 32'(rdata), 32'h3C);
        chk("err_sticky", 32'(sel_err), 32'h1);
        rsel = 2'd2;
        tick();
        chk("bad_rd2", 32'(rdata), 32'hF0);

        // clr with a simultaneous write: write dropped
        clr = 1'b1;
        wr(4'b0001, 8'hEE);
        clr = 1'b0;
        chk("clr_err", 32'(sel_err), 32'h0);
        chk("clr_mask", 32'(valid_mask), 32'h0);
        chk("clr_count", 32'(count), 32'd0);
        rsel = 2'd0;
        tick();
        chk("clr_keep", 32'(rdata), 32'h77);
        chk("clr_rvalid", 32'(rvalid), 32'h0);

        // Dump entries 1 and 3 with ready high
        wr(4'b0010, 8'h22);
        wr(4'b1000, 8'h44);
        chk("d1_mask", 32'(valid_mask), 32'hA);
        chk("d1_count", 32'(count), 32'd2);
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("d1_busy_k", 32'(dump_busy), 32'h1);
        chk("d1_v_k", 32'(dump_valid), 32'h0);
        tick();
        chk_word("d1_w0", 1'b1, 2'd1, 8'h22);
        tick();
        chk("d1_gap", 32'(dump_valid), 32'h0);
        tick();
        chk_word("d1_w1", 1'b1, 2'd3, 8'h44);
        tick();
        chk("d1_gap2", 32'(dump_valid), 32'h0);
        chk("d1_nodone", 32'(dump_done), 32'h0);
        tick();
        chk("d1_done", 32'(dump_done), 32'h1);
        chk("d1_busy_done", 32'(dump_busy), 32'h1);
        tick();
        chk("d1_done_end", 32'(dump_done), 32'h0);
        chk("d1_idle", 32'(dump_busy), 32'h0);

        // Dump with 3 stall cycles and an overwrite of the held entry
        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        chk_word("st_c1", 1'b1, 2'd1, 8'h22);
        wr(4'b0010, 8'h55);
        chk_word("st_c2", 1'b1, 2'd1, 8'h22);
        tick();
        chk_word("st_c3", 1'b1, 2'd1, 8'h22);
        dump_ready = 1'b1;
        tick();
        chk("st_hs", 32'(dump_valid), 32'h0);
        tick();
        chk_word("st_w1", 1'b1, 2'd3, 8'h44);
        tick();
        tick();
        chk("st_done", 32'(dump_done), 32'h1);
        tick();
        chk("st_idle", 32'(dump_busy), 32'h0);
        rsel = 2'd1;
        tick();
        chk("st_rd1", 32'(rdata), 32'h55);

        // Empty snapshot
        clr = 1'b1;
        tick();
        clr = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("e_busy", 32'(dump_busy), 32'h1);
        chk("e_nodone", 32'(dump_done), 32'h0);
        tick();
        chk("e_done", 32'(dump_done), 32'h1);
        chk("e_v", 32'(dump_valid), 32'h0);
        tick();
        chk("e_done_end", 32'(dump_done), 32'h0);
        chk("e_idle", 32'(dump_busy), 32'h0);
        chk("e_v2", 32'(dump_valid), 32'h0);

        // clr while in SEND aborts without done
        wr(4'b0100, 8'h66);
        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        chk_word("ab_w", 1'b1, 2'd2, 8'h66);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ab_v", 32'(dump_valid), 32'h0);
        chk("ab_idle", 32'(dump_busy), 32'h0);
        chk("ab_nodone", 32'(dump_done), 32'h0);
        tick();
        chk("ab_nodone2", 32'(dump_done), 32'h0);
        chk("ab_v2", 32'(dump_valid), 32'h0);

        // Asynchronous reset mid-dump and mid-write
        rsel = 2'd0;
        wr(4'b0001, 8'hC3);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        chk_word("rs_w", 1'b1, 2'd0, 8'hC3);
        chk("rs_count", 32'(count), 32'd1);
        we    = 1'b1;
        wsel  = 4'b0001;
        wdata = 8'hAA;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        we = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        chk("rs_mem0", 32'(rdata), 32'h0);
        chk("rs_idle", 32'(dump_busy), 32'h0);
        chk("rs_count2", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
